rv32_decode_stage: RTL and testbench

Downstream neighbour of the instruction fetch stage in the RV32I core. Accepts `{pc, instruction}` beats from fetch, buffers up to two in a skid buffer so back-pressure never forms a combinational path, and decodes each into register indices, immediate, operation class and branch/jump targets. The targets feed back to fetch as its branch and jump addresses; the decoded bundle goes to the execute stage over a valid/ready handshake.

---
 rtl/rv32_pkg.sv | 49 ++++
 rtl/rv32_decoder.sv | 83 ++++++++
 rtl/rv32_decode_stage.sv | 92 +++++++++
 tb/tb_rv32_decode_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared types for the RV32I decode stage: operation classes, opcodes and the
// decoded bundle carried from decode to execute.
package rv32_pkg;

  typedef enum logic [3:0] {
    OP_ILLEGAL = 4'd0,
    OP_LUI,
    OP_AUIPC,
    OP_JAL,
    OP_JALR,
    OP_BRANCH,
    OP_LOAD,
    OP_STORE,
    OP_OPIMM,
    OP_OP,
    OP_FENCE,
    OP_SYSTEM
  } rv32_op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] pc;
    rv32_op_e    op;
    logic [2:0]  funct3;
    logic        alt;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        illegal;
  } rv32_dec_t;

endpackage

// File: rtl/rv32_decoder.sv
// Purely combinational RV32I decoder: instruction word and PC in, decoded
// bundle (fields, immediate, targets, legality) out.
module rv32_decoder
  import rv32_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output rv32_dec_t   dec
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] f3;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr[6:0];
  assign funct7 = instr[31:25];
  assign f3     = instr[14:12];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec               = '0;
    dec.pc            = pc;
    dec.funct3        = f3;
    dec.alt           = instr[30];
    // Targets are computed for every beat; fetch only uses them when it matters.
    dec.branch_target = pc + $unsigned(imm_b);
    dec.jump_target   = pc + $unsigned(imm_j);
    case (opcode)
      OPC_LUI: begin
        dec.op = OP_LUI;   dec.rd = instr[11:7]; dec.imm = imm_u;
      end
      OPC_AUIPC: begin
        dec.op = OP_AUIPC; dec.rd = instr[11:7]; dec.imm = imm_u;
      end
      OPC_JAL: begin
        dec.op = OP_JAL;   dec.rd = instr[11:7]; dec.imm = imm_j;
      end
      OPC_JALR: begin
        dec.op = OP_JALR;  dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.imm = imm_i;
        dec.illegal = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.op = OP_BRANCH; dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20]; dec.imm = imm_b;
        dec.illegal = (f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        dec.op = OP_LOAD;  dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.imm = imm_i;
        dec.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        dec.op = OP_STORE; dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20]; dec.imm = imm_s;
        dec.illegal = (f3 > 3'b010);
      end
      OPC_OPIMM: begin
        dec.op = OP_OPIMM; dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.imm = imm_i;
        dec.illegal = ((f3 == 3'b001) && (funct7 != F7_BASE)) ||
                      ((f3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT));
      end
      OPC_OP: begin
        dec.op = OP_OP; dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20];
        dec.illegal = ((funct7 != F7_BASE) && (funct7 != F7_ALT)) ||
                      ((funct7 == F7_ALT) && (f3 != 3'b000) && (f3 != 3'b101));
      end
      OPC_FENCE: begin
        dec.op = OP_FENCE;  dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.imm = imm_i;
      end
      OPC_SYSTEM: begin
        dec.op = OP_SYSTEM; dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.imm = imm_i;
      end
      default: begin
        dec.op      = OP_ILLEGAL;
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rv32_decode_stage.sv
// RV32I decode stage: decodes fetch beats and holds them in a two-entry skid
// buffer so that if_ready is a register and never depends on ex_ready.
module rv32_decode_stage
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  output logic            if_ready,
  input  logic            flush,
  output logic            id_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] id_pc,
  output rv32_op_e        id_op,
  output logic [2:0]      id_funct3,
  output logic            id_alt,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [4:0]      id_rd,
  output logic [XLEN-1:0] id_imm,
  output logic [XLEN-1:0] id_branch_target,
  output logic [XLEN-1:0] id_jump_target,
  output logic            id_illegal
);

  rv32_dec_t  dec_p0;
  rv32_dec_t  buf_p1 [2];
  rv32_dec_t  head_p1;
  logic [1:0] cnt, cnt_next;
  logic       head;
  logic       ready_q;
  logic       accept, pop;

  // Stage 0: combinational decode of the incoming fetch beat
  rv32_decoder u_decoder (
    .instr (if_instr),
    .pc    (if_pc),
    .dec   (dec_p0)
  );

  assign if_ready = ready_q;
  assign id_valid = (cnt != 2'd0);
  assign accept   = if_valid && ready_q;
  assign pop      = id_valid && ex_ready;

  always_comb begin
    cnt_next = cnt;
    if (flush)
      cnt_next = 2'd0;
    else if (accept && !pop)
      cnt_next = cnt + 2'd1;
    else if (pop && !accept)
      cnt_next = cnt - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= 2'd0;
      head    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      head    <= flush ? 1'b0 : (head ^ pop);
      ready_q <= (cnt_next < 2'd2);
    end
  end

  // Stage 1: buffered bundles; the tail slot sits one past head when one is held
  always_ff @(posedge clk) begin
    if (accept && !flush && !reset)
      buf_p1[head ^ cnt[0]] <= dec_p0;
  end

  assign head_p1 = id_valid ? buf_p1[head] : '0;

  assign id_pc            = head_p1.pc;
  assign id_op            = head_p1.op;
  assign id_funct3        = head_p1.funct3;
  assign id_alt           = head_p1.alt;
  assign id_rs1           = head_p1.rs1;
  assign id_rs2           = head_p1.rs2;
  assign id_rd            = head_p1.rd;
  assign id_imm           = head_p1.imm;
  assign id_branch_target = head_p1.branch_target;
  assign id_jump_target   = head_p1.jump_target;
  assign id_illegal       = head_p1.illegal;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Bench for rv32_decode_stage: a hand-derived vector table streamed through a
// scoreboard, plus back-pressure, flush and reset sequences.
module tb_rv32_decode_stage;
  import rv32_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    rv32_op_e    op;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, bt, jt;
    logic        ill;
    logic        full;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        flush;
  logic        id_valid;
  logic        ex_ready;
  logic [31:0] id_pc;
  rv32_op_e    id_op;
  logic [2:0]  id_funct3;
  logic        id_alt;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_imm, id_branch_target, id_jump_target;
  logic        id_illegal;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_pop  = 0;
  vec_t tbl[$];
  vec_t sb[$];
  vec_t cur;

  rv32_decode_stage #(.XLEN(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .if_instr         (if_instr),
    .if_ready         (if_ready),
    .flush            (flush),
    .id_valid         (id_valid),
    .ex_ready         (ex_ready),
    .id_pc            (id_pc),
    .id_op            (id_op),
    .id_funct3        (id_funct3),
    .id_alt           (id_alt),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_rd            (id_rd),
    .id_imm           (id_imm),
    .id_branch_target (id_branch_target),
    .id_jump_target   (id_jump_target),
    .id_illegal       (id_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(logic [31:0] instr, logic [31:0] pc, rv32_op_e op,
                              logic [2:0] f3, logic alt, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic [31:0] imm, logic [31:0] bt,
                              logic [31:0] jt, logic ill, logic full);
    vec_t v;
    v.instr = instr; v.pc = pc; v.op = op; v.f3 = f3; v.alt = alt;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.imm = imm; v.bt = bt; v.jt = jt;
    v.ill = ill; v.full = full;
    return v;
  endfunction

  function automatic vec_t mkc(logic [31:0] instr, logic [31:0] pc, rv32_op_e op, logic ill);
    return mk(instr, pc, op, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, ill, 1'b0);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_beat(vec_t e);
    logic [151:0] act, req;
    if (e.full) begin
      act = {id_pc, id_op, id_funct3, id_alt, id_rs1, id_rs2, id_rd, id_imm,
             id_branch_target, id_jump_target, id_illegal};
      req = {e.pc, e.op, e.f3, e.alt, e.rs1, e.rs2, e.rd, e.imm, e.bt, e.jt, e.ill};
    end else begin
      act = {115'd0, id_pc, id_op, id_illegal};
      req = {115'd0, e.pc, e.op, e.ill};
    end
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL beat instr=0x%08h: got 0x%0h, expected 0x%0h", e.instr, act, req);
    end
  endtask

  // Scoreboard: beats are queued as fetch hands them over and checked as execute takes them.
  always @(negedge clk) begin
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (id_valid && ex_ready) begin
        n_pop++;
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got pc 0x%08h, expected no beat", id_pc);
        end else begin
          check_beat(sb.pop_front());
        end
      end
      if (if_valid && if_ready) sb.push_back(cur);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_valid = 1'b0;
  endtask

  task automatic push_beat(vec_t v);
    logic acc;
    cur      = v;
    if_valid = 1'b1;
    if_instr = v.instr;
    if_pc    = v.pc;
    for (int k = 0; k < 16; k++) begin
      acc = if_ready;
      step();
      if (acc) return;
    end
    check("accept_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    // Full-field vectors (immediates and targets derived by hand from the encodings)
    tbl.push_back(mk(32'h00500093, 32'h0,   OP_OPIMM,  3'd0, 1'b0, 5'd0, 5'd0, 5'd1,
                     32'h5, 32'h800, 32'h804, 1'b0, 1'b1));
    tbl.push_back(mk(32'hFE208CE3, 32'h100, OP_BRANCH, 3'd0, 1'b1, 5'd1, 5'd2, 5'd0,
                     32'hFFFFFFF8, 32'hF8, 32'hFFF088E2, 1'b0, 1'b1));
    tbl.push_back(mk(32'h010000EF, 32'h20,  OP_JAL,    3'd0, 1'b0, 5'd0, 5'd0, 5'd1,
                     32'h10, 32'h820, 32'h30, 1'b0, 1'b1));
    tbl.push_back(mk(32'hFFFFFFFF, 32'h40,  OP_ILLEGAL, 3'd7, 1'b1, 5'd0, 5'd0, 5'd0,
                     32'h0, 32'h3E, 32'h3E, 1'b1, 1'b1));
    tbl.push_back(mk(32'h123452B7, 32'h0,   OP_LUI,    3'd5, 1'b0, 5'd0, 5'd0, 5'd5,
                     32'h12345000, 32'h924, 32'h45922, 1'b0, 1'b1));
    tbl.push_back(mk(32'h0020A623, 32'h200, OP_STORE,  3'd2, 1'b0, 5'd1, 5'd2, 5'd0,
                     32'hC, 32'h20C, 32'hA202, 1'b0, 1'b1));
    tbl.push_back(mk(32'h402081B3, 32'h300, OP_OP,     3'd0, 1'b1, 5'd1, 5'd2, 5'd3,
                     32'h0, 32'hF02, 32'h8702, 1'b0, 1'b1));
    // Class and legality only
    tbl.push_back(mkc(32'h022081B3, 32'h1000, OP_OP,      1'b1));
    tbl.push_back(mkc(32'h402091B3, 32'h1004, OP_OP,      1'b1));
    tbl.push_back(mkc(32'h40005033, 32'h1008, OP_OP,      1'b0));
    tbl.push_back(mkc(32'h0020A063, 32'h100C, OP_BRANCH,  1'b1));
    tbl.push_back(mkc(32'h00003003, 32'h1010, OP_LOAD,    1'b1));
    tbl.push_back(mkc(32'h00006003, 32'h1014, OP_LOAD,    1'b1));
    tbl.push_back(mkc(32'h00002003, 32'h1018, OP_LOAD,    1'b0));
    tbl.push_back(mkc(32'h00003023, 32'h101C, OP_STORE,   1'b1));
    tbl.push_back(mkc(32'h00001067, 32'h1020, OP_JALR,    1'b1));
    tbl.push_back(mkc(32'h00008067, 32'h1024, OP_JALR,    1'b0));
    tbl.push_back(mkc(32'h02001093, 32'h1028, OP_OPIMM,   1'b1));
    tbl.push_back(mkc(32'h40005093, 32'h102C, OP_OPIMM,   1'b0));
    tbl.push_back(mkc(32'h00000092, 32'h1030, OP_ILLEGAL, 1'b1));
    tbl.push_back(mkc(32'h0000000F, 32'h1034, OP_FENCE,   1'b0));
    tbl.push_back(mkc(32'h00000073, 32'h1038, OP_SYSTEM,  1'b0));
    tbl.push_back(mkc(32'h00000017, 32'h103C, OP_AUIPC,   1'b0));

    reset = 1'b1; flush = 1'b0; ex_ready = 1'b0;
    if_valid = 1'b0; if_pc = '0; if_instr = '0;
    cur = tbl[0];
    repeat (3) step();
    check("reset_if_ready", 64'(if_ready), 64'd0);
    check("reset_id_valid", 64'(id_valid), 64'd0);
    check("reset_id_pc",    64'(id_pc),    64'd0);
    check("reset_id_op",    64'(id_op),    64'd0);
    reset = 1'b0;
    step();
    check("if_ready_after_reset", 64'(if_ready), 64'd1);

    // Single beat: visible one edge after accept
    ex_ready = 1'b1;
    push_beat(tbl[0]);
    idle();
    check("latency_id_valid", 64'(id_valid), 64'd1);
    check("latency_id_rd",    64'(id_rd),    64'd1);
    check("latency_id_imm",   64'(id_imm),   64'd5);
    step();

    // Back-to-back stream of the whole table
    for (int i = 0; i < tbl.size(); i++) push_beat(tbl[i]);
    idle();
    repeat (3) step();
    check("stream_drained", 64'(sb.size()), 64'd0);

    // Back-pressure: A, B fill the buffer, C waits, then all three drain without gaps
    ex_ready = 1'b0;
    push_beat(tbl[1]);
    push_beat(tbl[2]);
    check("full_if_ready", 64'(if_ready), 64'd0);
    cur = tbl[4]; if_valid = 1'b1; if_instr = tbl[4].instr; if_pc = tbl[4].pc;
    step();
    check("held_if_ready", 64'(if_ready), 64'd0);
    check("held_head_pc",  64'(id_pc),    64'(tbl[1].pc));
    ex_ready = 1'b1;
    begin
      int p0;
      p0 = n_pop;
      push_beat(tbl[4]);
      idle();
      step();
      check("no_gap_pops", 64'(n_pop - p0), 64'd3);
    end
    check("drained_id_valid", 64'(id_valid), 64'd0);

    // Flush with one beat held: the same-cycle beat is dropped
    ex_ready = 1'b0;
    push_beat(tbl[5]);
    cur = tbl[6]; if_valid = 1'b1; if_instr = tbl[6].instr; if_pc = tbl[6].pc;
    flush = 1'b1;
    step();
    flush = 1'b0; idle();
    check("flush1_id_valid", 64'(id_valid), 64'd0);
    check("flush1_if_ready", 64'(if_ready), 64'd1);
    step();
    check("flush1_dropped",  64'(id_valid), 64'd0);

    // Flush with two beats held
    push_beat(tbl[5]);
    push_beat(tbl[6]);
    cur = tbl[0]; if_valid = 1'b1; if_instr = tbl[0].instr; if_pc = tbl[0].pc;
    flush = 1'b1;
    step();
    flush = 1'b0; idle();
    check("flush2_id_valid", 64'(id_valid), 64'd0);
    check("flush2_if_ready", 64'(if_ready), 64'd1);
    step();
    check("flush2_dropped",  64'(id_valid), 64'd0);

    // Traffic resumes after flush
    ex_ready = 1'b1;
    push_beat(tbl[3]);
    idle();
    repeat (2) step();
    check("post_flush_drained", 64'(sb.size()), 64'd0);

    // Reset with two beats buffered
    ex_ready = 1'b0;
    push_beat(tbl[1]);
    push_beat(tbl[2]);
    idle();
    reset = 1'b1;
    step();
    check("midreset_id_valid", 64'(id_valid), 64'd0);
    check("midreset_id_pc",    64'(id_pc),    64'd0);
    check("midreset_id_imm",   64'(id_imm),   64'd0);
    check("midreset_id_op",    64'(id_op),    64'd0);
    check("midreset_if_ready", 64'(if_ready), 64'd0);
    reset = 1'b0;
    step();
    check("post_reset_if_ready", 64'(if_ready), 64'd1);
    check("post_reset_id_valid", 64'(id_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
